cmv300_pixel_capture: RTL and testbench
=======================================

CMV300_PIXEL_CAPTURE -- requirements
Module: cmv300_pixel_capture

Interface
REQ-001 Parameter LINES, default 488: active lines per frame.
REQ-002 Parameter PIXELS, default 648: bytes per line; SHALL be a multiple of 4.
REQ-003 Parameter REQ_WIDTH, default 4: FRAME_REQ pulse length in clocks (1..15).
REQ-004 CVM300_CLK_OUT  in  1  sole clock, sensor output clock; all logic rising-edge.
REQ-005 RES_N  in  1  reset, asynchronous and active-low.
REQ-006 start  in  1  one-cycle request to capture one frame.
REQ-007 abort  in  1  one-cycle request to drop the current capture.
REQ-008 CVM300_Line_valid  in  1  sensor line-valid.
REQ-009 CVM300_Data_valid  in  1  sensor data-valid.
REQ-010 CVM300_D  in  8  pixel byte (8-bit mode).
REQ-011 fifo_full  in  1  downstream pipe-out FIFO full.
REQ-012 CVM300_FRAME_REQ  out  1  frame request to sensor.
REQ-013 wr_en  out  1  FIFO write strobe.
REQ-014 wr_data  out  32  packed pixel word.
REQ-015 pixel_cnt  out  10  bytes accepted in current line.
REQ-016 line_cnt  out  10  lines completed in current frame.
REQ-017 frame_cnt  out  16  frames completed since reset.
REQ-018 busy  out  1  high in any state other than IDLE.
REQ-019 done  out  1  one-cycle frame-complete pulse.
REQ-020 overflow  out  1  sticky: word dropped on fifo_full or byte beyond PIXELS.
REQ-021 state  out  3  current FSM state encoding, for ILA.

Function
REQ-022 States SHALL be IDLE=0, REQ=1, WAIT_LINE=2, CAPTURE=3, DONE=4.
REQ-023 IDLE: start -> REQ; clear pixel_cnt, line_cnt, byte index; overflow is not cleared.
REQ-024 REQ: CVM300_FRAME_REQ high for exactly REQ_WIDTH cycles, then -> WAIT_LINE.
REQ-025 WAIT_LINE: Line_valid high -> CAPTURE in the same cycle the high is sampled.
REQ-026 CAPTURE: byte accepted iff Line_valid and Data_valid are both high and pixel_cnt < PIXELS.
REQ-027 Accepted bytes pack little-endian: first byte to wr_data[7:0], fourth to [31:24].
REQ-028 On the 4th accepted byte, wr_en SHALL pulse high for one cycle on the next clock, with wr_data valid in that cycle.
REQ-029 If fifo_full is high at the 4th accepted byte: no wr_en, word dropped, overflow set.
REQ-030 Data_valid with pixel_cnt = PIXELS: byte discarded, overflow set, pixel_cnt holds.
REQ-031 Line_valid falling edge in CAPTURE: line_cnt +1, pixel_cnt and byte index cleared, partial word discarded.
REQ-032 Same falling edge with line_cnt+1 = LINES -> DONE; otherwise -> WAIT_LINE.
REQ-033 DONE: done high one cycle, frame_cnt +1 (wraps 65535 -> 0), -> IDLE.
REQ-034 start while busy SHALL be ignored.
REQ-035 abort in any non-IDLE state -> IDLE next cycle: FRAME_REQ low, no done pulse, frame_cnt unchanged, pending wr_en suppressed.
REQ-036 abort and start in the same cycle in IDLE: start wins.
REQ-037 Counters SHALL never exceed LINES/PIXELS; no wrap within a frame.

Reset
REQ-038 RES_N low SHALL immediately force state=IDLE and all outputs and counters to 0, including overflow and wr_data.
REQ-039 Reset mid-frame discards all captured data; no wr_en or done is generated during or after reset release until a new start.

Verification (LINES=2, PIXELS=8, REQ_WIDTH=4)
REQ-040 start, two lines of bytes 0x01..0x08 -> FRAME_REQ high 4 cycles; wr_data 0x04030201, 0x08070605 per line (4 wr_en); done once; frame_cnt=1.
REQ-041 Data_valid toggling every other cycle -> identical words, pixel_cnt=8 before each line end.
REQ-042 fifo_full high during 2nd word of line 1 -> 3 wr_en total, overflow=1 and stays 1 through next frame.
REQ-043 line of 10 bytes -> first 8 packed, last 2 discarded, overflow=1, pixel_cnt=8.
REQ-044 abort during line 2 -> IDLE next cycle, no done, frame_cnt unchanged; later start captures normally.
REQ-045 RES_N low mid-word -> all outputs 0 asynchronously; no wr_en after release without start.

Source files
------------

// File: rtl/cmv300_pixel_capture.sv
// CMV300 8-bit pixel capture: frame request, line/pixel counting, 4-byte packing.
// Ports: sensor clk/lines in, FIFO write strobe/word out, counters and status out.
module cmv300_pixel_capture #(
    parameter int LINES     = 488,
    parameter int PIXELS    = 648,
    parameter int REQ_WIDTH = 4
) (
    input  logic        CVM300_CLK_OUT,
    input  logic        RES_N,
    input  logic        start,
    input  logic        abort,
    input  logic        CVM300_Line_valid,
    input  logic        CVM300_Data_valid,
    input  logic [7:0]  CVM300_D,
    input  logic        fifo_full,
    output logic        CVM300_FRAME_REQ,
    output logic        wr_en,
    output logic [31:0] wr_data,
    output logic [9:0]  pixel_cnt,
    output logic [9:0]  line_cnt,
    output logic [15:0] frame_cnt,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_REQ       = 3'd1,
        S_WAIT_LINE = 3'd2,
        S_CAPTURE   = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    localparam logic [9:0] LAST_LINE = 10'(LINES - 1);
    localparam logic [9:0] PIX_MAX   = 10'(PIXELS);
    localparam logic [3:0] REQ_LAST  = 4'(REQ_WIDTH - 1);

    state_t      cur;
    state_t      nxt;
    logic [3:0]  req_cnt;
    logic [1:0]  byte_idx;
    logic [23:0] word_buf;

    logic in_line;
    logic take;
    logic spill;
    logic line_end;

    // A line may begin in the very cycle WAIT_LINE sees Line_valid,
    // so bytes are accepted there too; abort blocks all datapath updates.
    assign in_line  = (cur == S_WAIT_LINE || cur == S_CAPTURE)
                    && CVM300_Line_valid && !abort;
    assign take     = in_line && CVM300_Data_valid && (pixel_cnt < PIX_MAX);
    assign spill    = in_line && CVM300_Data_valid && (pixel_cnt == PIX_MAX);
    // CAPTURE is only entered with Line_valid high, so low here is the fall.
    assign line_end = (cur == S_CAPTURE) && !CVM300_Line_valid && !abort;

    always_ff @(posedge CVM300_CLK_OUT or negedge RES_N) begin
        if (!RES_N) begin
            cur <= S_IDLE;
        end else begin
            cur <= nxt;
        end
    end

    always_comb begin
        nxt = cur;
        case (cur)
            S_IDLE: begin
                if (start) nxt = S_REQ;
            end
            S_REQ: begin
                if (abort)                  nxt = S_IDLE;
                else if (req_cnt == REQ_LAST) nxt = S_WAIT_LINE;
            end
            S_WAIT_LINE: begin
                if (abort)                  nxt = S_IDLE;
                else if (CVM300_Line_valid) nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (abort) begin
                    nxt = S_IDLE;
                end else if (!CVM300_Line_valid) begin
                    if (line_cnt == LAST_LINE) nxt = S_DONE;
                    else                       nxt = S_WAIT_LINE;
                end
            end
            S_DONE: begin
                nxt = S_IDLE;
            end
            default: begin
                nxt = S_IDLE;
            end
        endcase
    end

    assign CVM300_FRAME_REQ = (cur == S_REQ);
    assign busy             = (cur != S_IDLE);
    assign done             = (cur == S_DONE);
    assign state            = cur;

    always_ff @(posedge CVM300_CLK_OUT or negedge RES_N) begin
        if (!RES_N) begin
            req_cnt   <= '0;
            byte_idx  <= '0;
            word_buf  <= '0;
            wr_en     <= 1'b0;
            wr_data   <= '0;
            pixel_cnt <= '0;
            line_cnt  <= '0;
            frame_cnt <= '0;
            overflow  <= 1'b0;
        end else begin
            wr_en <= 1'b0;

            if (cur == S_IDLE && start) begin
                req_cnt   <= '0;
                byte_idx  <= '0;
                pixel_cnt <= '0;
                line_cnt  <= '0;
            end

            if (cur == S_REQ && !abort) begin
                req_cnt <= req_cnt + 4'd1;
            end

            if (take) begin
                pixel_cnt <= pixel_cnt + 10'd1;
                byte_idx  <= byte_idx + 2'd1;
                case (byte_idx)
                    2'd0: word_buf[7:0]   <= CVM300_D;
                    2'd1: word_buf[15:8]  <= CVM300_D;
                    2'd2: word_buf[23:16] <= CVM300_D;
                    default: begin
                        // Word complete: write it out or drop it on full.
                        if (fifo_full) begin
                            overflow <= 1'b1;
                        end else begin
                            wr_en   <= 1'b1;
                            wr_data <= {CVM300_D, word_buf};
                        end
                    end
                endcase
            end

            if (spill) begin
                overflow <= 1'b1;
            end

            // Any partial word left at line end is simply forgotten.
            if (line_end) begin
                line_cnt  <= line_cnt + 10'd1;
                pixel_cnt <= '0;
                byte_idx  <= '0;
            end

            if (cur == S_DONE) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_cmv300_pixel_capture.sv
// Directed bench for cmv300_pixel_capture (LINES=2, PIXELS=8, REQ_WIDTH=4).
// Inputs change on the falling edge; outputs are observed on the falling edge.
module tb_cmv300_pixel_capture;

    localparam int LINES     = 2;
    localparam int PIXELS    = 8;
    localparam int REQ_WIDTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        lv = 1'b0;
    logic        dv = 1'b0;
    logic [7:0]  d = 8'h00;
    logic        fifo_full = 1'b0;
    logic        frame_req;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [9:0]  pixel_cnt;
    logic [9:0]  line_cnt;
    logic [15:0] frame_cnt;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [2:0]  state;

    int n_chk = 0;
    int n_fail = 0;
    int req_cycles = 0;
    int done_cnt = 0;
    logic [31:0] words[$];
    logic [31:0] exp_w[$];

    cmv300_pixel_capture #(
        .LINES    (LINES),
        .PIXELS   (PIXELS),
        .REQ_WIDTH(REQ_WIDTH)
    ) dut (
        .CVM300_CLK_OUT   (clk),
        .RES_N            (rst_n),
        .start            (start),
        .abort            (abort),
        .CVM300_Line_valid(lv),
        .CVM300_Data_valid(dv),
        .CVM300_D         (d),
        .fifo_full        (fifo_full),
        .CVM300_FRAME_REQ (frame_req),
        .wr_en            (wr_en),
        .wr_data          (wr_data),
        .pixel_cnt        (pixel_cnt),
        .line_cnt         (line_cnt),
        .frame_cnt        (frame_cnt),
        .busy             (busy),
        .done             (done),
        .overflow         (overflow),
        .state            (state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en)     words.push_back(wr_data);
        if (frame_req) req_cycles++;
        if (done)      done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input logic [2:0] s, input string tag);
        for (int i = 0; i < 40 && state !== s; i++) @(negedge clk);
        chk(tag, 32'(state), 32'(s));
    endtask

    task automatic pulse_start(input logic with_abort);
        start = 1'b1;
        abort = with_abort;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic clear_mon();
        words.delete();
        exp_w.delete();
        req_cycles = 0;
        done_cnt = 0;
    endtask

    task automatic exp_line8();
        exp_w.push_back(32'h04030201);
        exp_w.push_back(32'h08070605);
    endtask

    task automatic check_words(input string tag);
        chk({tag, "_nwords"}, 32'(words.size()), 32'(exp_w.size()));
        for (int i = 0; i < words.size() && i < exp_w.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), words[i], exp_w[i]);
    endtask

    // Bytes 1..n; ff_word marks the word index driven with fifo_full;
    // abort_at pulses abort together with that byte (0 = never).
    task automatic send_line(input int n, input logic gap,
                             input int ff_word, input int abort_at,
                             input string tag);
        lv = 1'b1;
        dv = 1'b0;
        @(negedge clk);
        for (int i = 1; i <= n; i++) begin
            dv = 1'b1;
            d = 8'(i);
            fifo_full = (ff_word >= 0) && ((i - 1) / 4 == ff_word);
            abort = (i == abort_at);
            @(negedge clk);
            abort = 1'b0;
            if (i == abort_at) begin
                chk({tag, "_abort_state"}, 32'(state), 32'd0);
                chk({tag, "_abort_busy"}, 32'(busy), 32'd0);
                lv = 1'b0;
                dv = 1'b0;
                fifo_full = 1'b0;
                tick(2);
                return;
            end
            if (gap) begin
                dv = 1'b0;
                @(negedge clk);
            end
        end
        dv = 1'b0;
        fifo_full = 1'b0;
        chk({tag, "_pix"}, 32'(pixel_cnt),
            32'((n > PIXELS) ? PIXELS : n));
        @(negedge clk);
        lv = 1'b0;
        tick(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_freq", 32'(frame_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_fcnt", 32'(frame_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);

        // Plain frame
        clear_mon();
        pulse_start(1'b0);
        chk("t1_busy", 32'(busy), 32'd1);
        wait_state(3'd2, "t1_wl");
        send_line(8, 1'b0, -1, 0, "t1l0");
        chk("t1_lcnt", 32'(line_cnt), 32'd1);
        send_line(8, 1'b0, -1, 0, "t1l1");
        wait_state(3'd0, "t1_idle");
        exp_line8();
        exp_line8();
        check_words("t1");
        chk("t1_req", 32'(req_cycles), 32'(REQ_WIDTH));
        chk("t1_done", 32'(done_cnt), 32'd1);
        chk("t1_fcnt", 32'(frame_cnt), 32'd1);
        chk("t1_lend", 32'(line_cnt), 32'd2);
        chk("t1_ovf", 32'(overflow), 32'd0);

        // Data_valid every other cycle
        clear_mon();
        pulse_start(1'b0);
        wait_state(3'd2, "t2_wl");
        send_line(8, 1'b1, -1, 0, "t2l0");
        send_line(8, 1'b1, -1, 0, "t2l1");
        wait_state(3'd0, "t2_idle");
        exp_line8();
        exp_line8();
        check_words("t2");
        chk("t2_fcnt", 32'(frame_cnt), 32'd2);

        // FIFO full on the second word of the first line
        clear_mon();
        pulse_start(1'b0);
        wait_state(3'd2, "t3_wl");
        send_line(8, 1'b0, 1, 0, "t3l0");
        send_line(8, 1'b0, -1, 0, "t3l1");
        wait_state(3'd0, "t3_idle");
        exp_w.push_back(32'h04030201);
        exp_line8();
        check_words("t3");
        chk("t3_ovf", 32'(overflow), 32'd1);
        chk("t3_fcnt", 32'(frame_cnt), 32'd3);

        // Overflow is sticky through a clean frame
        clear_mon();
        pulse_start(1'b0);
        wait_state(3'd2, "t3b_wl");
        send_line(8, 1'b0, -1, 0, "t3bl0");
        send_line(8, 1'b0, -1, 0, "t3bl1");
        wait_state(3'd0, "t3b_idle");
        exp_line8();
        exp_line8();
        check_words("t3b");
        chk("t3b_ovf", 32'(overflow), 32'd1);

        // Asynchronous reset mid-word
        pulse_start(1'b0);
        wait_state(3'd2, "t5_wl");
        lv = 1'b1;
        @(negedge clk);
        dv = 1'b1;
        d = 8'h11;
        @(negedge clk);
        d = 8'h22;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_state", 32'(state), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_pix", 32'(pixel_cnt), 32'd0);
        chk("t5_fcnt", 32'(frame_cnt), 32'd0);
        chk("t5_ovf", 32'(overflow), 32'd0);
        chk("t5_wdata", wr_data, 32'd0);
        chk("t5_wr_en", 32'(wr_en), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_mon();
        for (int i = 1; i <= 8; i++) begin
            d = 8'(i);
            @(negedge clk);
        end
        lv = 1'b0;
        dv = 1'b0;
        tick(3);
        chk("t5_nowr", 32'(words.size()), 32'd0);
        chk("t5_nodone", 32'(done_cnt), 32'd0);
        chk("t5_idle", 32'(state), 32'd0);

        // Line longer than PIXELS
        clear_mon();
        chk("t4_ovf0", 32'(overflow), 32'd0);
        pulse_start(1'b0);
        wait_state(3'd2, "t4_wl");
        send_line(10, 1'b0, -1, 0, "t4l0");
        chk("t4_ovf", 32'(overflow), 32'd1);
        send_line(8, 1'b0, -1, 0, "t4l1");
        wait_state(3'd0, "t4_idle");
        exp_line8();
        exp_line8();
        check_words("t4");
        chk("t4_fcnt", 32'(frame_cnt), 32'd1);

        // Abort on the 4th byte of line 2 drops the pending word
        clear_mon();
        pulse_start(1'b0);
        wait_state(3'd2, "t6_wl");
        send_line(8, 1'b0, -1, 0, "t6l0");
        send_line(8, 1'b0, -1, 4, "t6l1");
        exp_line8();
        check_words("t6");
        chk("t6_done", 32'(done_cnt), 32'd0);
        chk("t6_fcnt", 32'(frame_cnt), 32'd1);

        // start with abort in IDLE, start ignored while busy
        clear_mon();
        pulse_start(1'b1);
        chk("t7_req", 32'(state), 32'd1);
        wait_state(3'd2, "t7_wl");
        pulse_start(1'b0);
        chk("t7_ign", 32'(state), 32'd2);
        send_line(8, 1'b0, -1, 0, "t7l0");
        send_line(8, 1'b0, -1, 0, "t7l1");
        wait_state(3'd0, "t7_idle");
        exp_line8();
        exp_line8();
        check_words("t7");
        chk("t7_done", 32'(done_cnt), 32'd1);
        chk("t7_fcnt", 32'(frame_cnt), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
